// File: rtl/joy_db15_pkg.sv
// Shared constants for the DB15 joystick link: FSM state codes, chain length and button bit positions.
package joy_db15_pkg;

    localparam int JOY_BITS_DEFAULT = 12;
    localparam int CHAIN_LEN        = 2 * JOY_BITS_DEFAULT;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Button positions within one player word, format LS FEDCBAUDLR
    localparam int BTN_R  = 0;
    localparam int BTN_L  = 1;
    localparam int BTN_DN = 2;
    localparam int BTN_UP = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_C  = 6;
    localparam int BTN_D  = 7;
    localparam int BTN_E  = 8;
    localparam int BTN_F  = 9;
    localparam int BTN_S  = 10;
    localparam int BTN_ML = 11;

endpackage

// File: rtl/joy_db15_tx_pin_sync_edge.sv
// N-stage synchroniser for an asynchronous pin, with one-cycle rise/fall pulses from a trailing flop.
module pin_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Device side of the DB15 serial joystick link: 74165-style load/shift chain of two player words.
// Optional stale-link detector built when JOY_DB15_TX_STALE_EN is defined.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int BITS_PER_PLAYER = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int STALE_CYCLES    = 2400000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [BITS_PER_PLAYER-1:0] joy1_in,
    input  logic [BITS_PER_PLAYER-1:0] joy2_in,
    input  logic                       joy_load_n,
    input  logic                       joy_clk,
    output logic                       joy_data,
    output logic                       frame_done,
    output logic [4:0]                 bit_index,
    output logic                       link_stale,
    output logic [1:0]                 fsm_state
);

    localparam int         CHAIN_N   = 2 * BITS_PER_PLAYER;
    localparam logic [4:0] LAST_IDX  = 5'(CHAIN_N - 1);
    localparam logic [4:0] CHAIN_IDX = 5'(CHAIN_N);

    logic               load_level, load_rise, load_fall;
    logic               clk_level, clk_rise, clk_fall;
    logic [1:0]         state;
    logic [CHAIN_N-1:0] shadow;
    logic [CHAIN_N-1:0] snap;
    logic [4:0]         idx_q;

    pin_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_load_sync (
        .clk(clk), .reset_n(reset_n), .pin(joy_load_n),
        .level(load_level), .rise(load_rise), .fall(load_fall)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
        .clk(clk), .reset_n(reset_n), .pin(joy_clk),
        .level(clk_level), .rise(clk_rise), .fall(clk_fall)
    );

    // Wire level is active-low; player 1 leaves the chain first
    assign snap = {~joy2_in, ~joy1_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            shadow     <= '1;
            idx_q      <= '0;
            joy_data   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_fall) begin
                // A new latch always wins, aborting any frame in flight
                shadow   <= snap;
                idx_q    <= '0;
                joy_data <= snap[0];
                state    <= ST_LOAD;
            end else begin
                case (state)
                    ST_LOAD: begin
                        shadow   <= snap;
                        joy_data <= snap[0];
                        if (load_rise) state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (clk_rise && load_level) begin
                            shadow <= {1'b1, shadow[CHAIN_N-1:1]};
                            if (idx_q == LAST_IDX) begin
                                idx_q      <= CHAIN_IDX;
                                frame_done <= 1'b1;
                                joy_data   <= 1'b1;
                                state      <= ST_DRAIN;
                            end else begin
                                idx_q    <= idx_q + 5'd1;
                                joy_data <= shadow[1];
                            end
                        end
                    end
                    default: joy_data <= 1'b1;
                endcase
            end
        end
    end

    assign bit_index = idx_q;
    assign fsm_state = state;

`ifdef JOY_DB15_TX_STALE_EN
    localparam int SW = $clog2(STALE_CYCLES + 1);

    logic [SW-1:0] stale_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stale_cnt <= SW'(STALE_CYCLES);
        end else if (load_fall) begin
            stale_cnt <= '0;
        end else if (stale_cnt != SW'(STALE_CYCLES)) begin
            stale_cnt <= stale_cnt + 1'b1;
        end
    end

    assign link_stale = (stale_cnt == SW'(STALE_CYCLES));

    logic unused_ok;
    assign unused_ok = &{1'b0, clk_level, clk_fall};
`else
    assign link_stale = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk_level, clk_fall, (STALE_CYCLES != 0)};
`endif

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: pin-level host driver, frame-level reference model, per-cycle compare.
module tb_joy_db15_tx;
    import joy_db15_pkg::*;

    localparam int NB    = 12;
    localparam int CL    = 2 * NB;
    localparam int STALE = 100;
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [NB-1:0] joy1_in = '0;
    logic [NB-1:0] joy2_in = '0;
    logic          joy_load_n = 1'b1;
    logic          joy_clk = 1'b0;
    logic          joy_data;
    logic          frame_done;
    logic [4:0]    bit_index;
    logic          link_stale;
    logic [1:0]    fsm_state;

    joy_db15_tx #(.BITS_PER_PLAYER(NB), .SYNC_STAGES(2), .STALE_CYCLES(STALE)) dut (
        .clk(clk), .reset_n(reset_n), .joy1_in(joy1_in), .joy2_in(joy2_in),
        .joy_load_n(joy_load_n), .joy_clk(joy_clk), .joy_data(joy_data),
        .frame_done(frame_done), .bit_index(bit_index), .link_stale(link_stale),
        .fsm_state(fsm_state)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_seen = 0;
    bit cmp_en   = 1'b0;

    // Frame-level model: the whole chain as a vector, a position and a mode
    logic [CL-1:0] m_stream;
    int            m_idx = 0;
    logic          m_data = 1'b1;
    logic          m_done = 1'b0;
    int            m_mode = 0;  // 0 idle, 1 latched, 2 shifting, 3 drained
    int            m_load_cyc = 0;
    bit            m_loaded = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_stale();
`ifdef JOY_DB15_TX_STALE_EN
        return !m_loaded || ((cyc - m_load_cyc) >= STALE);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("joy_data", 32'(joy_data), 32'(m_data));
            check("bit_index", 32'(bit_index), 32'(m_idx));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("link_stale", 32'(link_stale), 32'(exp_stale()));
            if (frame_done) done_seen++;
        end
    end

    task automatic model_reset();
        m_idx = 0; m_data = 1'b1; m_done = 1'b0; m_mode = 0; m_loaded = 1'b0;
    endtask

    task automatic model_load();
        m_stream   = {~joy2_in, ~joy1_in};
        m_idx      = 0;
        m_data     = m_stream[0];
        m_mode     = 1;
        m_load_cyc = cyc;
        m_loaded   = 1'b1;
    endtask

    task automatic model_shift();
        if (m_mode == 2) begin
            m_idx++;
            if (m_idx == CL) begin
                m_done = 1'b1;
                m_mode = 3;
                m_data = 1'b1;
            end else begin
                m_data = m_stream[m_idx];
            end
        end
    endtask

    task automatic lat();
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        m_done = 1'b0;
    endtask

    task automatic set_load(input logic v);
        logic prev;
        prev = joy_load_n;
        joy_load_n = v;
        lat();
        if (prev && !v) model_load();
        else if (!prev && v && m_mode == 1) m_mode = 2;
        settle();
    endtask

    task automatic set_clk(input logic v);
        logic prev;
        prev = joy_clk;
        joy_clk = v;
        lat();
        if (!prev && v && joy_load_n) model_shift();
        settle();
    endtask

    task automatic clk_pulse();
        set_clk(1'b1);
        set_clk(1'b0);
    endtask

    task automatic load_frame(input logic [NB-1:0] j1, input logic [NB-1:0] j2);
        joy1_in = j1;
        joy2_in = j2;
        set_load(1'b0);
        set_load(1'b1);
    endtask

    task automatic coincident();
        joy_load_n = 1'b0;
        joy_clk    = 1'b1;
        lat();
        model_load();
        settle();
        set_clk(1'b0);
        set_load(1'b1);
    endtask

    task automatic capture_frame(output logic [CL-1:0] got, input int change_at, input logic [NB-1:0] new_j1);
        got[0] = joy_data;
        for (int i = 1; i < CL; i++) begin
            if (i == change_at) joy1_in = new_j1;
            set_clk(1'b1);
            got[i] = joy_data;
            set_clk(1'b0);
        end
        clk_pulse();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CL-1:0] got;
        int d0;

        #5;
        reset_n = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        #1;
        check("rst_joy_data", 32'(joy_data), 32'd1);
        check("rst_bit_index", 32'(bit_index), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
`ifdef JOY_DB15_TX_STALE_EN
        check("rst_link_stale", 32'(link_stale), 32'd1);
`else
        check("rst_link_stale", 32'(link_stale), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Clocks in idle change nothing
        clk_pulse();
        clk_pulse();
        check("idle_clk_index", 32'(bit_index), 32'd0);
        check("idle_clk_data", 32'(joy_data), 32'd1);

        // Single button R on player 1
        d0 = done_seen;
        load_frame(12'h001, 12'h000);
        capture_frame(got, -1, '0);
        check("stream_001", 32'(got), 32'h00FFFFFE);
        check("done_once_001", 32'(done_seen - d0), 32'd1);
        check("index_sat_001", 32'(bit_index), 32'd24);

        // Mixed pattern on both players
        d0 = done_seen;
        load_frame(12'hA5A, 12'h3C3);
        capture_frame(got, -1, '0);
        check("stream_a5a_3c3", 32'(got), 32'h00C3C5A5);
        check("done_once_a5a", 32'(done_seen - d0), 32'd1);

        // Input change mid-frame does not leak into the frame
        load_frame(12'h000, 12'h000);
        capture_frame(got, 6, 12'hFFF);
        check("stream_frozen", 32'(got), 32'h00FFFFFF);

        // Reload at clock 10 aborts, then 30 clocks drain
        d0 = done_seen;
        load_frame(12'hA5A, 12'h3C3);
        for (int i = 0; i < 10; i++) clk_pulse();
        load_frame(12'h00F, 12'h800);
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        check("reload_index", 32'(bit_index), 32'd0);
        check("reload_data", 32'(joy_data), 32'd0);
        for (int i = 0; i < 30; i++) clk_pulse();
        check("drain_done_once", 32'(done_seen - d0), 32'd1);
        check("drain_index", 32'(bit_index), 32'd24);
        check("drain_data", 32'(joy_data), 32'd1);

        // Load fall and clock rise together: load wins
        load_frame(12'h0F0, 12'h00F);
        for (int i = 0; i < 3; i++) clk_pulse();
        joy1_in = 12'h001;
        coincident();
        check("coincident_index", 32'(bit_index), 32'd0);
        check("coincident_data", 32'(joy_data), 32'd0);

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 5; i++) clk_pulse();
        reset_n = 1'b0;
        model_reset();
        #2;
        check("midrst_data", 32'(joy_data), 32'd1);
        check("midrst_index", 32'(bit_index), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        clk_pulse();
        check("post_rst_data", 32'(joy_data), 32'd1);

        // Randomised frames, aborts, and ignored clocks under load
        for (int it = 0; it < 40; it++) begin
            int n;
            joy1_in = NB'($urandom_range(0, 4095));
            joy2_in = NB'($urandom_range(0, 4095));
            set_load(1'b0);
            if ($urandom_range(0, 3) == 0) clk_pulse();
            set_load(1'b1);
            n = $urandom_range(0, 30);
            for (int k = 0; k < n; k++) begin
                if (k == n / 2 && $urandom_range(0, 1) == 1) begin
                    joy1_in = NB'($urandom_range(0, 4095));
                    joy2_in = NB'($urandom_range(0, 4095));
                end
                clk_pulse();
            end
            if ($urandom_range(0, 4) == 0) coincident();
        end

        // Long idle period for the stale detector
        repeat (STALE + 10) @(posedge clk);
        #1;
`ifdef JOY_DB15_TX_STALE_EN
        check("stale_after_idle", 32'(link_stale), 32'd1);
`else
        check("stale_after_idle", 32'(link_stale), 32'd0);
`endif

        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
